// File: rtl/vend_dispense_sequencer.sv
// rtl/vend_dispense_sequencer.sv - vend request queue and actuator sequencer
//
// Purpose:
//   Queues vend events from the coin-counting FSM and executes them one at a
//   time: timed motor pulse, drop confirmation with timeout, optional
//   coin-return pulse, then a settle gap. A missed drop parks the sequencer
//   in a sticky fault until fault_clr_i discards the failed entry.
//
// Ports:
//   clk               clock
//   rst_n             asynchronous active-low reset
//   ena_i             global enable; low freezes every register
//   req_valid_i       vend request strobe
//   req_change_i      request also owes change (sampled with req_valid_i)
//   req_ready_o       queue can accept (not full and enabled)
//   drop_sensor_i     product-drop detector, active-high
//   fault_clr_i       clears the drop-timeout fault
//   motor_on_o        product motor drive (registered)
//   coin_return_on_o  change solenoid drive (registered)
//   busy_o            sequencer active or queue non-empty
//   fault_o           sticky drop-timeout fault (registered)
//   pending_o         queue occupancy
//   served_cnt_o      successful vends, wraps at 256

`timescale 1ns/1ps

module vend_dispense_sequencer #(
  parameter int DEPTH         = 4,
  parameter int MOTOR_CYCLES  = 16,
  parameter int DROP_TIMEOUT  = 64,
  parameter int CHANGE_CYCLES = 8,
  parameter int GAP_CYCLES    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena_i,
  input  logic                       req_valid_i,
  input  logic                       req_change_i,
  output logic                       req_ready_o,
  input  logic                       drop_sensor_i,
  input  logic                       fault_clr_i,
  output logic                       motor_on_o,
  output logic                       coin_return_on_o,
  output logic                       busy_o,
  output logic                       fault_o,
  output logic [$clog2(DEPTH+1)-1:0] pending_o,
  output logic [7:0]                 served_cnt_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  localparam int TMAX_A = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
  localparam int TMAX_B = (CHANGE_CYCLES > GAP_CYCLES) ? CHANGE_CYCLES : GAP_CYCLES;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] MOTOR_LAST  = TW'(MOTOR_CYCLES - 1);
  localparam logic [TW-1:0] DROP_LAST   = TW'(DROP_TIMEOUT - 1);
  localparam logic [TW-1:0] CHANGE_LAST = TW'(CHANGE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST    = TW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MOTOR     = 3'd1,
    S_WAIT_DROP = 3'd2,
    S_CHANGE    = 3'd3,
    S_GAP       = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            change_q, change_d;
  logic            drop_seen_q, drop_seen_d;
  logic [7:0]      served_q, served_d;
  logic            motor_q, coin_q, fault_q;

  logic [DEPTH-1:0] fifo_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic full, empty, push, pop;

  // Full comes from the registered count, so a pop in the same cycle never
  // opens a slot for a push.
  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  assign req_ready_o = !full && ena_i;
  assign push        = req_valid_i && req_ready_o;
  assign pop         = ena_i && (state_q == S_IDLE) && !empty;

  // Request queue: one change bit per entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= req_change_i;
        wr_ptr_q         <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Sequencer state register. Actuator outputs follow the state one cycle
  // later, which places the first motor cycle two edges after the push.
  // Fault tracks the next state so it rises on FAULT entry and drops on the
  // edge that takes fault_clr_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      change_q    <= 1'b0;
      drop_seen_q <= 1'b0;
      served_q    <= '0;
      motor_q     <= 1'b0;
      coin_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else if (ena_i) begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      change_q    <= change_d;
      drop_seen_q <= drop_seen_d;
      served_q    <= served_d;
      motor_q     <= (state_q == S_MOTOR);
      coin_q      <= (state_q == S_CHANGE);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    change_d    = change_q;
    drop_seen_d = drop_seen_q;
    served_d    = served_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          change_d    = fifo_q[rd_ptr_q];
          drop_seen_d = 1'b0;
          timer_d     = '0;
          state_d     = S_MOTOR;
        end
      end

      S_MOTOR: begin
        // A fast product can fall while the motor still runs; remember it.
        if (drop_sensor_i) begin
          drop_seen_d = 1'b1;
        end
        if (timer_q == MOTOR_LAST) begin
          timer_d = '0;
          state_d = S_WAIT_DROP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_WAIT_DROP: begin
        if (drop_sensor_i || drop_seen_q) begin
          served_d = served_q + 8'd1;
          timer_d  = '0;
          state_d  = change_q ? S_CHANGE : S_GAP;
        end else if (timer_q == DROP_LAST) begin
          timer_d = '0;
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_CHANGE: begin
        if (timer_q == CHANGE_LAST) begin
          timer_d = '0;
          state_d = S_GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_FAULT: begin
        // The failed entry was already popped; leaving is enough to drop it.
        if (fault_clr_i) begin
          timer_d = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign motor_on_o       = motor_q;
  assign coin_return_on_o = coin_q;
  assign fault_o          = fault_q;
  assign busy_o           = (state_q != S_IDLE) || !empty;
  assign pending_o        = count_q;
  assign served_cnt_o     = served_q;

endmodule
